// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - timed square-wave sound effects with mute and a one-deep request buffer
module tone_sequencer #(
  parameter int HALF0   = 13636,
  parameter int HALF1   = 10204,
  parameter int HALF2   = 6818,
  parameter int HALF3   = 3409,
  parameter int DUR_CYC = 1200000,
  parameter int GAP_CYC = 120000,
  parameter int CW      = 24
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       play,
  input  logic [1:0] code_sound,
  input  logic       mute,
  output logic       sound,
  output logic       busy,
  output logic [1:0] code_playing,
  output logic       pending
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  localparam logic [CW-1:0] DUR_M1 = CW'(DUR_CYC - 1);
  localparam logic [CW-1:0] GAP_M1 = CW'(GAP_CYC - 1);

  state_t        state, state_n;
  logic          play_q, rise;
  logic          tone_on, tone_n;
  logic          busy_n, pend_n;
  logic [1:0]    code_n, pcode, pcode_n, idle_code;
  logic [CW-1:0] half_cnt, half_n, dur_cnt, dur_n, gap_cnt, gap_n;

  function automatic logic [CW-1:0] half_m1(input logic [1:0] c);
    case (c)
      2'd0:    half_m1 = CW'(HALF0 - 1);
      2'd1:    half_m1 = CW'(HALF1 - 1);
      2'd2:    half_m1 = CW'(HALF2 - 1);
      default: half_m1 = CW'(HALF3 - 1);
    endcase
  endfunction

  assign rise      = play & ~play_q;
  assign sound     = tone_on & ~mute;
  // A fresh edge in IDLE wins over a request buffered on the GAP exit cycle
  assign idle_code = rise ? code_sound : pcode;

  always_comb begin
    state_n = state;
    tone_n  = tone_on;
    busy_n  = busy;
    pend_n  = pending;
    pcode_n = pcode;
    code_n  = code_playing;
    half_n  = half_cnt;
    dur_n   = dur_cnt;
    gap_n   = gap_cnt;
    case (state)
      IDLE: begin
        if (rise || pending) begin
          state_n = PLAY;
          code_n  = idle_code;
          tone_n  = 1'b1;
          half_n  = half_m1(idle_code);
          dur_n   = DUR_M1;
          busy_n  = 1'b1;
          pend_n  = 1'b0;
        end
      end
      PLAY: begin
        if (rise) begin
          pend_n  = 1'b1;
          pcode_n = code_sound;
        end
        if (dur_cnt == '0) begin
          state_n = GAP;
          tone_n  = 1'b0;
          gap_n   = GAP_M1;
        end else begin
          dur_n = dur_cnt - 1'b1;
          if (half_cnt == '0) begin
            tone_n = ~tone_on;
            half_n = half_m1(code_playing);
          end else begin
            half_n = half_cnt - 1'b1;
          end
        end
      end
      GAP: begin
        if (rise) begin
          pend_n  = 1'b1;
          pcode_n = code_sound;
        end
        if (gap_cnt == '0) begin
          if (pending) begin
            // Consume the old buffer; an edge on this same cycle stays buffered
            state_n = PLAY;
            code_n  = pcode;
            tone_n  = 1'b1;
            half_n  = half_m1(pcode);
            dur_n   = DUR_M1;
            pend_n  = rise;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end else begin
          gap_n = gap_cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        tone_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state        <= IDLE;
      play_q       <= 1'b0;
      tone_on      <= 1'b0;
      busy         <= 1'b0;
      pending      <= 1'b0;
      pcode        <= 2'b00;
      code_playing <= 2'b00;
      half_cnt     <= '0;
      dur_cnt      <= '0;
      gap_cnt      <= '0;
    end else begin
      state        <= state_n;
      play_q       <= play;
      tone_on      <= tone_n;
      busy         <= busy_n;
      pending      <= pend_n;
      pcode        <= pcode_n;
      code_playing <= code_n;
      half_cnt     <= half_n;
      dur_cnt      <= dur_n;
      gap_cnt      <= gap_n;
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - scoreboard bench for tone_sequencer against a tone-timeline model
module tb_tone_sequencer;

  localparam int D = 40;
  localparam int G = 5;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       play = 1'b0;
  logic [1:0] code_sound = 2'b00;
  logic       mute = 1'b0;
  logic       sound, busy, pending;
  logic [1:0] code_playing;

  int checks = 0;
  int failures = 0;

  logic [4:0] expq[$];
  int         cycq[$];

  bit         m_active = 0, m_pend = 0, m_prev = 0;
  int         m_start = 0;
  logic [1:0] m_cur = 2'b00, m_pcode = 2'b00;
  int         n = 0;
  logic       rp = 1'b0;

  tone_sequencer #(
    .HALF0(4), .HALF1(3), .HALF2(2), .HALF3(1),
    .DUR_CYC(D), .GAP_CYC(G), .CW(24)
  ) dut (
    .clk(clk), .clr(clr), .play(play), .code_sound(code_sound), .mute(mute),
    .sound(sound), .busy(busy), .code_playing(code_playing), .pending(pending)
  );

  always #5 clk = ~clk;

  function automatic int half_of(input logic [1:0] c);
    case (c)
      2'd0:    return 4;
      2'd1:    return 3;
      2'd2:    return 2;
      default: return 1;
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model to the following clock edge, queue the expectation
  task automatic step(input logic p, input logic [1:0] c, input logic m, input logic r,
                      input bit async_clr = 0);
    bit rise;
    int a;
    logic snd;
    @(negedge clk);
    play = p;
    code_sound = c;
    mute = m;
    clr = async_clr ? 1'b0 : r;
    if (async_clr) begin
      #1 clr = 1'b1;
      #1;
      checks++;
      if ({sound, busy, pending} !== 3'b000) begin
        failures++;
        $display("FAIL async_clr t=%0t got sound/busy/pending=%b want=000", $time, {sound, busy, pending});
      end
    end
    n++;
    if (r || async_clr) begin
      m_active = 0; m_pend = 0; m_prev = 0; m_cur = 2'b00; m_pcode = 2'b00;
    end else begin
      rise = p && !m_prev;
      m_prev = p;
      if (m_active) begin
        if (n - m_start == D + G) begin
          if (m_pend) begin
            m_start = n; m_cur = m_pcode; m_pend = 0;
          end else begin
            m_active = 0;
          end
          if (rise) begin m_pend = 1; m_pcode = c; end
        end else if (rise) begin
          m_pend = 1; m_pcode = c;
        end
      end else if (rise) begin
        m_active = 1; m_start = n; m_cur = c; m_pend = 0;
      end else if (m_pend) begin
        m_active = 1; m_start = n; m_cur = m_pcode; m_pend = 0;
      end
    end
    a = n - m_start;
    snd = m_active && (a < D) && (((a / half_of(m_cur)) % 2) == 0) && !m;
    expq.push_back({snd, m_active, m_pend, m_cur});
    cycq.push_back(n);
  endtask

  task automatic idle(input int k, input logic m = 1'b0);
    repeat (k) step(1'b0, 2'($urandom), m, 1'b0);
  endtask

  initial begin : monitor
    logic [4:0] e;
    int cyc;
    forever begin
      @(posedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        cyc = cycq.pop_front();
        checks++;
        if ({sound, busy, pending, code_playing} !== e) begin
          failures++;
          $display("FAIL outputs cyc=%0d got sound,busy,pending,code=%b want=%b",
                   cyc, {sound, busy, pending, code_playing}, e);
        end
      end
    end
  end

  initial begin : driver
    repeat (3) step(1'b0, 2'd0, 1'b0, 1'b1);
    // single code-0 tone
    step(1'b1, 2'd0, 1'b0, 1'b0);
    idle(50);
    // code 3 with code_sound wandering mid-tone
    step(1'b1, 2'd3, 1'b0, 1'b0);
    idle(50);
    // two requests during PLAY, latest code buffered
    step(1'b1, 2'd0, 1'b0, 1'b0);
    idle(5);
    step(1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b0, 2'd1, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 2'd2, 1'b0, 1'b0);
    step(1'b0, 2'd2, 1'b0, 1'b0);
    idle(100);
    // held play gives a single tone
    repeat (200) step(1'b1, 2'd1, 1'b0, 1'b0);
    idle(5);
    // fully muted tone, then a tone unmuted partway through
    step(1'b1, 2'd2, 1'b1, 1'b0);
    idle(50, 1'b1);
    step(1'b1, 2'd0, 1'b1, 1'b0);
    idle(15, 1'b1);
    idle(40, 1'b0);
    // asynchronous clear mid-PLAY with a request pending
    step(1'b1, 2'd0, 1'b0, 1'b0);
    idle(5);
    step(1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b0, 2'd1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1);
    step(1'b1, 2'd3, 1'b0, 1'b0);
    idle(50);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rp = ~rp;
      if ($urandom_range(0, 699) == 0)
        step(rp, 2'($urandom), 1'b0, 1'b0, 1);
      else
        step(rp, 2'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 999) == 0));
    end
    idle(3);
    @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending expectations want=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
